muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide execute unit directly downstream of the register-file/decode stage.
- Consumes the rs/rt read data (read_data_1 → operand_a, read_data_2 → operand_b) and the decoded op.
- Produces the HI/LO architectural registers, read by MFHI/MFLO.
- A start/busy/done handshake lets the control unit stall the core while an operation runs.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  launch op; sampled only in IDLE.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- operand_a  in  WIDTH  rs data (multiplicand/dividend).
- operand_b  in  WIDTH  rt data (multiplier/divisor).
- flush  in  1  synchronous abort of the running op.
- mthi  in  1  write wdata to HI.
- mtlo  in  1  write wdata to LO.
- wdata  in  WIDTH  rs data for MTHI/MTLO.
- busy  out  1  high while an op is in progress.
- done  out  1  one-cycle pulse when HI/LO have just been updated by an op.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset: asynchronous on reset_n=0. State=IDLE; hi, lo, counter and internal accumulators = 0; busy=0, done=0. A reset mid-operation discards the op.
- State IDLE:
  - start=1 latches op, operand magnitudes and result-sign flags (signed ops only; unsigned ops use raw values).
  - Clears the counter; next state CALC.
- State CALC: one iteration per clock, WIDTH clocks total.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring, 1 quotient bit per clock.
  - When counter = WIDTH-1, next state FIXUP.
- State FIXUP: one clock.
  - Applies sign correction: product negated if signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
  - Writes hi/lo at the end of FIXUP; done=1 during the following cycle (registered).
  - Next state IDLE.
- Latency: start sampled at edge N → hi/lo valid and done=1 after edge N+WIDTH+1. busy=1 from edge N to edge N+WIDTH+1; busy = (state != IDLE).
- start while busy: ignored; no queuing.
- Back-to-back: start is accepted in the same cycle done is high, since state is IDLE.
- flush=1 in CALC/FIXUP: next state IDLE, hi/lo unchanged, done not asserted. flush has priority over start in IDLE.
- mthi/mtlo: honoured only when busy=0; ignored while busy. Writes take effect at the next edge. Both asserted together write both registers.
- Divide by zero (operand_b=0): the op still takes full latency; lo=all ones, hi=operand_a (raw, no sign fix).
- Signed overflow 0x80000000 / -1: lo=0x80000000, hi=0. Falls out of magnitude arithmetic; must not be trapped.
- Multiply result: hi = upper WIDTH bits, lo = lower WIDTH bits of the 2*WIDTH product.

Optional Feature:
- Macro: MULDIV_FAST_MULT_EN.
- Defined: MULT/MULTU use a single combinational WIDTH×WIDTH multiplier. IDLE → FIXUP directly, so hi/lo are valid and done=1 after edge N+1, with busy=1 for exactly one cycle. Divide is unchanged.
- Undefined: iterative multiply as above; no hardware multiplier inferred.

Decomposition:
- Shared package muldiv_pkg:
  - op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU;
  - state enum IDLE/CALC/FIXUP;
  - DIV0_QUOTIENT (all ones) constant.
- One natural sub-module, muldiv_signfix (combinational):
  - absolute value of operands on entry;
  - conditional negation of product/quotient/remainder on exit.
- Shared by both op classes. FSM, counter and accumulators stay in the top module.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=7 → after WIDTH+1 edges: hi=0xFFFFFFFF, lo=0xFFFFFFEB, done one cycle, busy low afterwards.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=0x64, b=0 → lo=0xFFFFFFFF, hi=0x00000064, full latency. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Start DIV, pulse flush at iteration 10 → busy drops next cycle, no done, hi/lo retain prior values. Second start during busy → ignored, result is of the first op.
- mthi wdata=0x1234 while busy → ignored. mthi/mtlo together with wdata=0xABCD when idle → hi=lo=0xABCD next cycle.
- reset_n low mid-CALC → immediate busy=0, done=0, hi=lo=0. Release, then MULT 5×6 → lo=30, hi=0. Repeat with MULDIV_FAST_MULT_EN defined → same result after 1 edge.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states, the divide-by-zero quotient and small op-decoding helpers.
package muldiv_pkg;

  // Widest datapath the shared constants are sized for; users slice down.
  localparam int unsigned MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CALC  = 2'b01,
    FIXUP = 2'b10
  } state_e;

  // Quotient reported for a zero divisor (all ones at any width).
  localparam logic [MAX_WIDTH-1:0] DIV0_QUOTIENT = '1;

  function automatic logic op_is_signed(input op_e o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

  function automatic logic op_is_div(input op_e o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Combinational sign handling shared by multiply and divide: operand
// magnitudes on entry, conditional negation of product, quotient and
// remainder on exit.
module muldiv_signfix
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   operand_a,
  input  logic [WIDTH-1:0]   operand_b,
  output logic [WIDTH-1:0]   abs_a,
  output logic [WIDTH-1:0]   abs_b,
  output logic               neg_a,
  output logic               neg_b,
  input  logic [2*WIDTH-1:0] product,
  input  logic               neg_product,
  input  logic [WIDTH-1:0]   quotient,
  input  logic               neg_quotient,
  input  logic [WIDTH-1:0]   remainder,
  input  logic               neg_remainder,
  output logic [2*WIDTH-1:0] product_fixed,
  output logic [WIDTH-1:0]   quotient_fixed,
  output logic [WIDTH-1:0]   remainder_fixed
);

  // Magnitudes of the incoming operands and sign-corrected results.
  always_comb begin
    // NOTE: every output is assigned on every path, so no latch can be inferred.
    neg_a           = is_signed & operand_a[WIDTH-1];
    neg_b           = is_signed & operand_b[WIDTH-1];
    abs_a           = neg_a ? -operand_a : operand_a;
    abs_b           = neg_b ? -operand_b : operand_b;
    product_fixed   = neg_product   ? -product   : product;
    quotient_fixed  = neg_quotient  ? -quotient  : quotient;
    remainder_fixed = neg_remainder ? -remainder : remainder;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide execute unit producing the HI/LO registers.
// MULT/MULTU use shift-add, DIV/DIVU restoring division, one bit per clock.
// Build option MULDIV_FAST_MULT_EN: multiplies use a single combinational
// multiplier and skip the CALC state; divides are unchanged.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flush,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e               state;
  logic                 is_div_r;
  logic                 div0_r;
  logic                 neg_res_r;
  logic                 neg_rem_r;
  logic [WIDTH-1:0]     operand_r;   // multiplicand (mult) or divisor (div)
  logic [WIDTH-1:0]     raw_a_r;     // unmodified dividend for divide-by-zero
  logic [2*WIDTH-1:0]   acc_r;
  logic [CNT_W-1:0]     counter_r;
  logic [WIDTH-1:0]     hi_r;
  logic [WIDTH-1:0]     lo_r;
  logic                 done_r;

  op_e                  op_in;
  logic                 start_is_div;
  logic                 start_is_signed;
  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;
  logic                 neg_a;
  logic                 neg_b;
  logic [2*WIDTH-1:0]   product_fixed;
  logic [WIDTH-1:0]     quotient_fixed;
  logic [WIDTH-1:0]     remainder_fixed;

  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_trial;
  logic [WIDTH:0]       div_diff;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_rem;
  logic [2*WIDTH-1:0]   acc_next;

  assign op_in           = op_e'(op);
  assign start_is_div    = op_is_div(op_in);
  assign start_is_signed = op_is_signed(op_in);

  assign busy = (state != IDLE);
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

  // Entry uses the live operands; exit uses the accumulator halves
  // (quotient in the low half, remainder in the high half for divides).
  muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
    .is_signed       (start_is_signed),
    .operand_a       (operand_a),
    .operand_b       (operand_b),
    .abs_a           (abs_a),
    .abs_b           (abs_b),
    .neg_a           (neg_a),
    .neg_b           (neg_b),
    .product         (acc_r),
    .neg_product     (neg_res_r),
    .quotient        (acc_r[WIDTH-1:0]),
    .neg_quotient    (neg_res_r),
    .remainder       (acc_r[2*WIDTH-1:WIDTH]),
    .neg_remainder   (neg_rem_r),
    .product_fixed   (product_fixed),
    .quotient_fixed  (quotient_fixed),
    .remainder_fixed (remainder_fixed)
  );

  // One iteration step: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    mul_sum   = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
              + {1'b0, (acc_r[0] ? operand_r : {WIDTH{1'b0}})};
    div_trial = acc_r[2*WIDTH-1:WIDTH-1];
    div_diff  = div_trial - {1'b0, operand_r};
    div_ge    = ~div_diff[WIDTH];
    div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
    if (is_div_r) begin
      acc_next = {div_rem, acc_r[WIDTH-2:0], div_ge};
    end else begin
      acc_next = {mul_sum, acc_r[WIDTH-1:1]};
    end
  end

  // Control FSM with the datapath registers and the HI/LO architectural state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      is_div_r  <= 1'b0;
      div0_r    <= 1'b0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      operand_r <= '0;
      raw_a_r   <= '0;
      acc_r     <= '0;
      counter_r <= '0;
      hi_r      <= '0;
      lo_r      <= '0;
      done_r    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (mthi) hi_r <= wdata;
          if (mtlo) lo_r <= wdata;
          if (start && !flush) begin
            is_div_r  <= start_is_div;
            div0_r    <= start_is_div && (operand_b == '0);
            neg_res_r <= neg_a ^ neg_b;
            neg_rem_r <= neg_a;
            raw_a_r   <= operand_a;
            counter_r <= '0;
            if (start_is_div) begin
              acc_r     <= {{WIDTH{1'b0}}, abs_a};
              operand_r <= abs_b;
              state     <= CALC;
            end else begin
`ifdef MULDIV_FAST_MULT_EN
              acc_r     <= {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
              operand_r <= abs_a;
              state     <= FIXUP;
`else
              acc_r     <= {{WIDTH{1'b0}}, abs_b};
              operand_r <= abs_a;
              state     <= CALC;
`endif
            end
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            acc_r     <= acc_next;
            counter_r <= counter_r + CNT_W'(1);
            if (counter_r == CNT_W'(WIDTH - 1)) state <= FIXUP;
          end
        end
        FIXUP: begin
          state <= IDLE;
          if (!flush) begin
            done_r <= 1'b1;
            if (!is_div_r) begin
              hi_r <= product_fixed[2*WIDTH-1:WIDTH];
              lo_r <= product_fixed[WIDTH-1:0];
            end else if (div0_r) begin
              hi_r <= raw_a_r;
              lo_r <= DIV0_QUOTIENT[WIDTH-1:0];
            end else begin
              hi_r <= remainder_fixed;
              lo_r <= quotient_fixed;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: scoreboard of expected HI/LO pairs
// pushed at launch and popped when done pulses.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;
  localparam int BOUND = 2 * WIDTH + 10;
`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = WIDTH + 1;
`endif
  localparam int DIV_LAT = WIDTH + 1;

  logic             clock;
  logic             reset_n;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             flush;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_hi  = '0;
  logic [31:0] last_lo  = '0;

  muldiv_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .flush     (flush),
    .mthi      (mthi),
    .mtlo      (mtlo),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference behaviour written with native SV arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] ps;
    logic [63:0]        pu;
    logic signed [31:0] sa;
    logic signed [31:0] sbv;
    logic signed [31:0] q;
    logic signed [31:0] r;
    sa  = a;
    sbv = b;
    case (o)
      OP_MULT: begin
        ps = 64'(sa) * 64'(sbv);
        return ps;
      end
      OP_MULTU: begin
        pu = {32'b0, a} * {32'b0, b};
        return pu;
      end
      OP_DIV: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sa / sbv;
        r = sa % sbv;
        return {r, q};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic drive_start(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start     = 1'b1;
    op        = o;
    operand_a = a;
    operand_b = b;
  endtask

  // Present an op for one edge; optionally record its expected result.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input bit push);
    drive_start(o, a, b);
    if (push) sb.push_back('{hi: ehi, lo: elo, lat: (o[1] ? DIV_LAT : MUL_LAT)});
    @(negedge clock);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL launch_busy: busy=%b required 1", busy);
    end
  endtask

  // Wait for done, then compare latency and HI/LO against the scoreboard head.
  task automatic wait_result(input string name, input int elapsed, input bit check_after);
    int   waits;
    exp_t e;
    waits = elapsed;
    while (done !== 1'b1 && waits < BOUND) begin
      @(negedge clock);
      waits++;
    end
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_scoreboard: done seen with no expected entry", name);
      return;
    end
    e = sb.pop_front();
    n_checks++;
    if (waits !== e.lat) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d cycles required %0d (done=%b)", name, waits, e.lat, done);
    end
    n_checks++;
    if (hi !== e.hi) begin
      n_fail++;
      $display("FAIL %s_hi: got %h required %h", name, hi, e.hi);
    end
    n_checks++;
    if (lo !== e.lo) begin
      n_fail++;
      $display("FAIL %s_lo: got %h required %h", name, lo, e.lo);
    end
    last_hi = e.hi;
    last_lo = e.lo;
    if (check_after) begin
      @(negedge clock);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_after: done=%b busy=%b required 0 0", name, done, busy);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #2;
    n_checks++;
    if ({busy, done, hi, lo} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h required all 0", busy, done, hi, lo);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_plan_ops();
    launch(OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1);
    wait_result("mult_neg", 0, 1'b1);
    launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
    wait_result("multu_max", 0, 1'b1);
    launch(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
    wait_result("div_neg", 0, 1'b1);
    launch(OP_DIVU, 32'h64, 32'h0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
    wait_result("divu_zero", 0, 1'b1);
    launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b1);
    wait_result("div_ovf", 0, 1'b1);
  endtask

  task automatic test_flush();
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;
    bit          seen;
    prev_hi = last_hi;
    prev_lo = last_lo;
    seen    = 1'b0;
    launch(OP_DIV, 32'd1000, 32'd3, 32'h0, 32'h0, 1'b0);
    repeat (10) @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle: busy=%b done=%b required 0 0", busy, done);
    end
    repeat (WIDTH + 3) begin
      @(negedge clock);
      if (done === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL flush_no_done: done pulsed after flush, required none");
    end
    n_checks++;
    if (hi !== prev_hi || lo !== prev_lo) begin
      n_fail++;
      $display("FAIL flush_keep: hi=%h lo=%h required %h %h", hi, lo, prev_hi, prev_lo);
    end
  endtask

  task automatic test_ignore_start();
    launch(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
    drive_start(OP_MULT, 32'd5, 32'd6);
    @(negedge clock);
    start = 1'b0;
    wait_result("ignore_start", 1, 1'b1);
  endtask

  task automatic test_mt_busy();
    logic [31:0] prev_hi;
    prev_hi = last_hi;
    launch(OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b1);
    mthi  = 1'b1;
    wdata = 32'h1234;
    @(negedge clock);
    mthi = 1'b0;
    n_checks++;
    if (hi !== prev_hi) begin
      n_fail++;
      $display("FAIL mthi_busy: hi=%h required %h", hi, prev_hi);
    end
    wait_result("mt_busy_op", 1, 1'b1);
  endtask

  task automatic test_mt_idle();
    wdata = 32'hABCD;
    mthi  = 1'b1;
    mtlo  = 1'b1;
    @(negedge clock);
    mthi = 1'b0;
    mtlo = 1'b0;
    n_checks++;
    if (hi !== 32'hABCD || lo !== 32'hABCD) begin
      n_fail++;
      $display("FAIL mt_both: hi=%h lo=%h required 0000abcd 0000abcd", hi, lo);
    end
    wdata = 32'h5555;
    mthi  = 1'b1;
    @(negedge clock);
    mthi = 1'b0;
    n_checks++;
    if (hi !== 32'h5555 || lo !== 32'hABCD) begin
      n_fail++;
      $display("FAIL mthi_only: hi=%h lo=%h required 00005555 0000abcd", hi, lo);
    end
  endtask

  task automatic test_reset_mid();
    launch(OP_DIV, 32'd12345, 32'd17, 32'h0, 32'h0, 1'b0);
    repeat (5) @(negedge clock);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, hi, lo} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h required all 0", busy, done, hi, lo);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    launch(OP_MULT, 32'd5, 32'd6, 32'd0, 32'd30, 1'b1);
    wait_result("mult_after_reset", 0, 1'b1);
  endtask

  task automatic test_back_to_back();
    launch(OP_MULT, 32'hFFFF_FFF6, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFE2, 1'b1);
    wait_result("b2b_first", 0, 1'b0);
    launch(OP_DIV, 32'h7FFF_FFFF, 32'hFFFF_FFF0, 32'h0000_000F, 32'hF800_0001, 1'b1);
    wait_result("b2b_second", 0, 1'b1);
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] r;
    for (int i = 0; i < 8; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(1, 40)) : $urandom;
      r = model(o, a, b);
      launch(o, a, b, r[63:32], r[31:0], 1'b1);
      wait_result("random", 0, 1'b1);
    end
  endtask

  // Hard stop in case a bounded wait is somehow bypassed.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    op        = 2'b00;
    operand_a = '0;
    operand_b = '0;
    flush     = 1'b0;
    mthi      = 1'b0;
    mtlo      = 1'b0;
    wdata     = '0;
    test_reset();
    test_plan_ops();
    test_flush();
    test_ignore_start();
    test_mt_busy();
    test_mt_idle();
    test_reset_mid();
    test_back_to_back();
    test_random();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
